alu_op_sequencer: RTL and testbench

Command-driven initiator for the 16-bit ALU (yAlu). It accepts one operation per valid/ready handshake, reads source operands from a small internal register file, drives the ALU's a/b/op inputs from registers, captures z/zero, and writes the result back. It is the control/datapath front end that turns the combinational ALU into a multi-cycle execute unit.

---
 rtl/alu_op_sequencer_if.sv | 29 ++
 rtl/alu_op_sequencer.sv | 120 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - command/result handshake bundle for the ALU op sequencer
interface alu_op_sequencer_if #(
    parameter int DW = 16,
    parameter int AW = 2
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    cmd_op;
    logic [AW-1:0] cmd_rd;
    logic [AW-1:0] cmd_rs1;
    logic [AW-1:0] cmd_rs2;
    logic [DW-1:0] cmd_imm;
    logic          res_valid;
    logic [DW-1:0] res_data;
    logic          res_zero;
    logic          res_err;

    // Issuer side: drives commands, observes results.
    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        input  cmd_ready, res_valid, res_data, res_zero, res_err
    );

    // Sequencer side: accepts commands, produces results.
    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        output cmd_ready, res_valid, res_data, res_zero, res_err
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - multi-cycle execute front end around a combinational 16-bit ALU
module alu_op_sequencer #(
    parameter int DW   = 16,
    parameter int NREG = 4,
    parameter int AW   = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    alu_op_sequencer_if.slave   bus,
    output logic [DW-1:0]       alu_a,
    output logic [DW-1:0]       alu_b,
    output logic [2:0]          alu_op,
    input  logic [DW-1:0]       alu_z,
    input  logic                alu_zero,
    input  logic [AW-1:0]       dbg_addr,
    output logic [DW-1:0]       dbg_data
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;
    typedef enum logic [1:0] {K_ALU, K_LOADI, K_ILLEGAL} kind_t;

    state_t        state;
    kind_t         kind_q;
    logic [DW-1:0] regfile [NREG];
    logic [AW-1:0] rd_q;
    logic [DW-1:0] imm_q;
    logic [DW-1:0] z_q;
    logic          zero_q;
    logic          res_valid_q;
    logic [DW-1:0] res_data_q;
    logic          res_zero_q;
    logic          res_err_q;

    // Only IDLE accepts; reset forces ready low even though state is already IDLE.
    assign bus.cmd_ready = (state == S_IDLE) && reset_n;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_zero  = res_zero_q;
    assign bus.res_err   = res_err_q;
    assign dbg_data      = regfile[dbg_addr];

    // Sequencer FSM: accept -> (EXEC) -> WB, with the register file written at the end of WB.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            kind_q      <= K_ALU;
            for (int i = 0; i < NREG; i++) begin
                regfile[i] <= '0;
            end
            rd_q        <= '0;
            imm_q       <= '0;
            z_q         <= '0;
            zero_q      <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_zero_q  <= 1'b0;
            res_err_q   <= 1'b0;
        end else begin
            res_valid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        // Operands are taken now, so rd==rs1/rs2 sees the pre-write value.
                        alu_a  <= regfile[bus.cmd_rs1];
                        alu_b  <= regfile[bus.cmd_rs2];
                        alu_op <= bus.cmd_op[2:0];
                        rd_q   <= bus.cmd_rd;
                        imm_q  <= bus.cmd_imm;
                        case (bus.cmd_op)
                            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111: begin
                                kind_q <= K_ALU;
                                state  <= S_EXEC;
                            end
                            4'b1000: begin
                                kind_q <= K_LOADI;
                                state  <= S_WB;
                            end
                            default: begin
                                kind_q <= K_ILLEGAL;
                                state  <= S_WB;
                            end
                        endcase
                    end
                end
                S_EXEC: begin
                    // ALU inputs have been stable for a full cycle; capture its outputs.
                    z_q    <= alu_z;
                    zero_q <= alu_zero;
                    state  <= S_WB;
                end
                S_WB: begin
                    res_valid_q <= 1'b1;
                    case (kind_q)
                        K_ALU: begin
                            regfile[rd_q] <= z_q;
                            res_data_q    <= z_q;
                            res_zero_q    <= zero_q;
                            res_err_q     <= 1'b0;
                        end
                        K_LOADI: begin
                            regfile[rd_q] <= imm_q;
                            res_data_q    <= imm_q;
                            res_err_q     <= 1'b0;
                        end
                        default: begin
                            res_data_q    <= '0;
                            res_err_q     <= 1'b1;
                        end
                    endcase
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;

    localparam int DW = 16;
    localparam int AW = 2;

    logic          clk;
    logic          reset_n;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [2:0]    alu_op;
    logic [DW-1:0] alu_z;
    logic          alu_zero;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;

    alu_op_sequencer_if #(.DW(DW), .AW(AW)) bus ();

    alu_op_sequencer #(.DW(DW), .NREG(4), .AW(AW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_z    (alu_z),
        .alu_zero (alu_zero),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Behavioural yAlu
    always_comb begin
        alu_z = '0;
        case (alu_op)
            3'b000: alu_z = alu_a & alu_b;
            3'b001: alu_z = alu_a | alu_b;
            3'b010: alu_z = alu_a + alu_b;
            3'b110: alu_z = alu_a - alu_b;
            3'b111: alu_z = ($signed(alu_a) < $signed(alu_b)) ? 16'd1 : 16'd0;
            default: alu_z = '0;
        endcase
    end
    assign alu_zero = (alu_z == '0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int            r_lat;
    logic [DW-1:0] r_data;
    logic          r_zero;
    logic          r_err;
    logic [2:0]    r_aluop;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                           input logic [1:0] rs2, input logic [15:0] imm);
        int w;
        @(negedge clk);
        bus.cmd_op    = op;
        bus.cmd_rd    = rd;
        bus.cmd_rs1   = rs1;
        bus.cmd_rs2   = rs2;
        bus.cmd_imm   = imm;
        bus.cmd_valid = 1'b1;
        w = 0;
        while (!bus.cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        r_aluop = alu_op;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        r_lat = 0;
        do begin
            @(posedge clk);
            #1;
            r_lat++;
        end while (!bus.res_valid && r_lat < 10);
        r_data = bus.res_data;
        r_zero = bus.res_zero;
        r_err  = bus.res_err;
    endtask

    task automatic dbg_check(input string tag, input logic [1:0] idx, input logic [15:0] exp);
        dbg_addr = idx;
        #1;
        check(tag, dbg_data, exp);
    endtask

    initial begin
        int rdy_seq;
        int acc;
        int seen_valid;

        reset_n       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_rd    = '0;
        bus.cmd_rs1   = '0;
        bus.cmd_rs2   = '0;
        bus.cmd_imm   = '0;
        dbg_addr      = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", bus.cmd_ready, 0);
        check("rst_valid", bus.res_valid, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_zero", bus.res_zero, 0);
        dbg_check("rst_r0", 2'd0, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("post_rst_ready", bus.cmd_ready, 1);

        // SUB to zero
        run_cmd(4'b1000, 2'd1, 2'd0, 2'd0, 16'h0005);
        check("loadi_lat", r_lat, 1);
        check("loadi_data", r_data, 16'h0005);
        check("loadi_err", r_err, 0);
        run_cmd(4'b1000, 2'd2, 2'd0, 2'd0, 16'h0005);
        run_cmd(4'b0110, 2'd3, 2'd1, 2'd2, 16'h0000);
        check("sub_lat", r_lat, 2);
        check("sub_data", r_data, 16'h0000);
        check("sub_zero", r_zero, 1);
        dbg_check("sub_r3", 2'd3, 16'h0000);

        // signed SLT and wrapping ADD
        run_cmd(4'b1000, 2'd0, 2'd0, 2'd0, 16'hFFFF);
        run_cmd(4'b1000, 2'd1, 2'd0, 2'd0, 16'h0001);
        run_cmd(4'b0111, 2'd2, 2'd0, 2'd1, 16'h0000);
        check("slt_data", r_data, 16'h0001);
        check("slt_zero", r_zero, 0);
        run_cmd(4'b0010, 2'd3, 2'd0, 2'd1, 16'h0000);
        check("add_wrap_data", r_data, 16'h0000);
        check("add_wrap_zero", r_zero, 1);

        // illegal op keeps state untouched
        run_cmd(4'b0100, 2'd3, 2'd0, 2'd1, 16'h1234);
        check("ill_lat", r_lat, 1);
        check("ill_err", r_err, 1);
        check("ill_data", r_data, 16'h0000);
        check("ill_zero", r_zero, 1);
        dbg_check("ill_r3", 2'd3, 16'h0000);
        dbg_check("ill_r0", 2'd0, 16'hFFFF);
        run_cmd(4'b1000, 2'd0, 2'd0, 2'd0, 16'hF0F0);
        check("after_ill_err", r_err, 0);
        check("after_ill_data", r_data, 16'hF0F0);
        check("loadi_keeps_zero", r_zero, 1);

        // AND / OR
        run_cmd(4'b1000, 2'd1, 2'd0, 2'd0, 16'h3C3C);
        run_cmd(4'b0000, 2'd2, 2'd0, 2'd1, 16'h0000);
        check("and_data", r_data, 16'h3030);
        check("and_zero", r_zero, 0);
        check("and_aluop", r_aluop, 3'b000);
        run_cmd(4'b0001, 2'd3, 2'd0, 2'd1, 16'h0000);
        check("or_data", r_data, 16'hFCFC);
        check("or_aluop", r_aluop, 3'b001);
        check("or_alu_a_hold", alu_a, 16'hF0F0);

        // rd==rs1==rs2 with cmd_valid held high
        run_cmd(4'b1000, 2'd1, 2'd0, 2'd0, 16'h4000);
        @(negedge clk);
        bus.cmd_op    = 4'b0010;
        bus.cmd_rd    = 2'd1;
        bus.cmd_rs1   = 2'd1;
        bus.cmd_rs2   = 2'd1;
        bus.cmd_valid = 1'b1;
        rdy_seq = 0;
        acc = 0;
        for (int i = 0; i < 3; i++) begin
            rdy_seq = (rdy_seq << 1) | int'(bus.cmd_ready);
            if (bus.cmd_ready && bus.cmd_valid) acc++;
            @(negedge clk);
        end
        rdy_seq = (rdy_seq << 1) | int'(bus.cmd_ready);
        check("hold_ready_seq", rdy_seq, 4'b1001);
        check("hold_accepts", acc, 1);
        check("hold_res_valid", bus.res_valid, 1);
        check("hold_add_data", bus.res_data, 16'h8000);
        bus.cmd_valid = 1'b0;
        dbg_check("hold_r1", 2'd1, 16'h8000);
        repeat (4) @(negedge clk);
        dbg_check("hold_r1_single", 2'd1, 16'h8000);

        // reset during EXEC aborts the command
        @(negedge clk);
        bus.cmd_op    = 4'b0010;
        bus.cmd_rd    = 2'd2;
        bus.cmd_rs1   = 2'd0;
        bus.cmd_rs2   = 2'd1;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        check("abort_in_exec_ready", bus.cmd_ready, 0);
        @(negedge clk);
        reset_n = 1'b0;
        seen_valid = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.res_valid) seen_valid++;
        end
        check("abort_no_valid", seen_valid, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("abort_ready", bus.cmd_ready, 1);
        @(posedge clk);
        #1;
        check("abort_res_valid", bus.res_valid, 0);
        check("abort_alu_a", alu_a, 0);
        check("abort_alu_b", alu_b, 0);
        check("abort_alu_op", alu_op, 0);
        check("abort_res_data", bus.res_data, 0);
        check("abort_res_zero", bus.res_zero, 0);
        check("abort_res_err", bus.res_err, 0);
        dbg_check("abort_r2", 2'd2, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
